// File: rtl/program_loader.sv
// Byte-stream loader: assembles big-endian address/data records into CPU load-port
// writes while holding the CPU in reset, then releases or re-arrests it on command.
module program_loader #(
  parameter int          ADDR_W   = 10,
  parameter int          DATA_W   = 32,
  parameter logic [7:0]  CMD_DATA = 8'h01,
  parameter logic [7:0]  CMD_INST = 8'h02,
  parameter logic [7:0]  CMD_GO   = 8'hA5,
  parameter logic [7:0]  CMD_STOP = 8'h5A
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              done,
  output logic              cpu_rst,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] inst_data,
  output logic              write_instruction,
  output logic              write_data,
  output logic              running,
  output logic              halted,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_DATA, S_WRITE, S_RUN, S_HALT
  } state_e;

  localparam logic [ADDR_W:0] WC_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_e              state_q, state_d;
  logic                target_inst_q, target_inst_d;
  logic [15:0]         addr_q, addr_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [DATA_W-1:0]   inst_data_q, inst_data_d;
  logic                wr_inst_q, wr_inst_d;
  logic                wr_data_q, wr_data_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                error_q, error_d;
  logic                in_ready_q, in_ready_d;
  logic [ADDR_W:0]     word_count_q, word_count_d;
  logic                xfer;
  logic [DATA_W-1:0]   word_shifted;

  assign xfer         = in_valid & in_ready_q;
  assign word_shifted = {word_q[DATA_W-9:0], in_data};

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d        = state_q;
    target_inst_d  = target_inst_q;
    addr_d         = addr_q;
    word_d         = word_q;
    byte_cnt_d     = byte_cnt_q;
    address_d      = address_q;
    inst_data_d    = inst_data_q;
    wr_inst_d      = 1'b0;
    wr_data_d      = 1'b0;
    cpu_rst_d      = cpu_rst_q;
    error_d        = error_q;
    word_count_d   = word_count_q;

    case (state_q)
      S_IDLE: if (xfer) begin
        case (in_data)
          CMD_DATA, CMD_INST: begin
            target_inst_d = (in_data == CMD_INST);
            state_d       = S_ADDR_HI;
          end
          CMD_GO: begin
            cpu_rst_d = 1'b0;
            state_d   = S_RUN;
          end
          CMD_STOP: ;
          default:  error_d = 1'b1;
        endcase
      end
      S_ADDR_HI: if (xfer) begin
        addr_d[15:8] = in_data;
        state_d      = S_ADDR_LO;
      end
      S_ADDR_LO: if (xfer) begin
        addr_d[7:0] = in_data;
        byte_cnt_d  = 2'd0;
        state_d     = S_DATA;
      end
      S_DATA: if (xfer) begin
        word_d     = word_shifted;
        byte_cnt_d = byte_cnt_q + 2'd1;
        if (byte_cnt_q == 2'd3) begin
          // Strobes are set on the edge that takes the last byte, so they are high
          // exactly for the single WRITE cycle that follows.
          state_d     = S_WRITE;
          address_d   = addr_q[ADDR_W-1:0];
          inst_data_d = word_shifted;
          if (addr_q[15:ADDR_W] != '0) begin
            error_d = 1'b1;
          end else begin
            wr_inst_d = target_inst_q;
            wr_data_d = ~target_inst_q;
            if (word_count_q != WC_MAX) word_count_d = word_count_q + (ADDR_W+1)'(1);
          end
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_RUN, S_HALT: begin
        // STOP takes priority over a simultaneous done.
        if (xfer && in_data == CMD_STOP) begin
          cpu_rst_d    = 1'b1;
          word_count_d = '0;
          state_d      = S_IDLE;
        end else if (state_q == S_RUN && done) begin
          state_d = S_HALT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d != S_WRITE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      target_inst_q <= 1'b0;
      addr_q        <= '0;
      word_q        <= '0;
      byte_cnt_q    <= '0;
      address_q     <= '0;
      inst_data_q   <= '0;
      wr_inst_q     <= 1'b0;
      wr_data_q     <= 1'b0;
      cpu_rst_q     <= 1'b1;
      error_q       <= 1'b0;
      in_ready_q    <= 1'b0;
      word_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      target_inst_q <= target_inst_d;
      addr_q        <= addr_d;
      word_q        <= word_d;
      byte_cnt_q    <= byte_cnt_d;
      address_q     <= address_d;
      inst_data_q   <= inst_data_d;
      wr_inst_q     <= wr_inst_d;
      wr_data_q     <= wr_data_d;
      cpu_rst_q     <= cpu_rst_d;
      error_q       <= error_d;
      in_ready_q    <= in_ready_d;
      word_count_q  <= word_count_d;
    end
  end

  assign in_ready          = in_ready_q;
  assign cpu_rst           = cpu_rst_q;
  assign address           = address_q;
  assign inst_data         = inst_data_q;
  assign write_instruction = wr_inst_q;
  assign write_data        = wr_data_q;
  assign running           = (state_q == S_RUN);
  assign halted            = (state_q == S_HALT);
  assign error             = error_q;
  assign word_count        = word_count_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: record-level reference model plus
// directed protocol scenarios and a randomized run up to word_count saturation.
module tb_program_loader;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam logic [7:0] C_DATA = 8'h01, C_INST = 8'h02, C_GO = 8'hA5, C_STOP = 8'h5A;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              done = 1'b0;
  logic              in_ready, cpu_rst, write_instruction, write_data;
  logic              running, halted, error;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W:0]   word_count;

  program_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .done(done), .cpu_rst(cpu_rst), .address(address), .inst_data(inst_data),
    .write_instruction(write_instruction), .write_data(write_data),
    .running(running), .halted(halted), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Strobe monitor, sampled mid-cycle.
  int                n_wd = 0, n_wi = 0, n_halt = 0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [DATA_W-1:0] last_data = '0;
  always @(negedge clk) begin
    if (rst) begin
      if (write_data) n_wd++;
      if (write_instruction) n_wi++;
      if (write_data || write_instruction) begin
        last_addr = address;
        last_data = inst_data;
      end
      if (halted) n_halt++;
    end
  end

  // Reference model: record count and sticky error.
  int exp_wc  = 0;
  bit exp_err = 1'b0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    done     = 1'b0;
    rst      = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    tick(1);
    exp_wc  = 0;
    exp_err = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_byte_timeout: in_ready=%0b, required 1 within 20 cycles (byte %h)", in_ready, b);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_record(input string name, input logic [7:0] cmd, input logic [15:0] addr,
                             input logic [31:0] word, input bit gaps);
    int  wd0 = n_wd;
    int  wi0 = n_wi;
    bit  in_range = (addr < 16'd1024);
    int  exp_d = (in_range && cmd == C_DATA) ? 1 : 0;
    int  exp_i = (in_range && cmd == C_INST) ? 1 : 0;
    logic [7:0] bytes [7];
    bytes = '{cmd, addr[15:8], addr[7:0], word[31:24], word[23:16], word[15:8], word[7:0]};
    for (int k = 0; k < 7; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) tick($urandom_range(1, 2));
      send_byte(bytes[k]);
    end
    if (in_range) exp_wc = (exp_wc < 1024) ? exp_wc + 1 : 1024;
    else          exp_err = 1'b1;
    tick(2);
    checks++;
    if (n_wd - wd0 != exp_d) begin errors++; $display("FAIL %s write_data cycles: got %0d, required %0d", name, n_wd - wd0, exp_d); end
    checks++;
    if (n_wi - wi0 != exp_i) begin errors++; $display("FAIL %s write_instruction cycles: got %0d, required %0d", name, n_wi - wi0, exp_i); end
    if (in_range) begin
      checks++;
      if (last_addr !== addr[ADDR_W-1:0] || address !== addr[ADDR_W-1:0]) begin
        errors++; $display("FAIL %s address: strobe %h, held %h, required %h", name, last_addr, address, addr[ADDR_W-1:0]);
      end
      checks++;
      if (last_data !== word || inst_data !== word) begin
        errors++; $display("FAIL %s inst_data: strobe %h, held %h, required %h", name, last_data, inst_data, word);
      end
    end
    checks++;
    if (word_count !== (ADDR_W+1)'(exp_wc)) begin errors++; $display("FAIL %s word_count: got %0d, required %0d", name, word_count, exp_wc); end
    checks++;
    if (error !== exp_err) begin errors++; $display("FAIL %s error: got %0b, required %0b", name, error, exp_err); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({cpu_rst, in_ready, write_data, write_instruction, running, halted, error} !== 7'b1000000) begin
      errors++; $display("FAIL reset_flags: got %b, required 1000000", {cpu_rst, in_ready, write_data, write_instruction, running, halted, error});
    end
    checks++;
    if (word_count !== '0 || address !== '0 || inst_data !== '0) begin
      errors++; $display("FAIL reset_values: wc=%0d addr=%h data=%h, required all 0", word_count, address, inst_data);
    end
    rst = 1'b1;
    tick(2);
    checks++;
    if ({cpu_rst, in_ready, write_data, write_instruction, running, halted} !== 6'b110000 || word_count !== '0) begin
      errors++; $display("FAIL idle_after_reset: flags=%b wc=%0d, required 110000 wc=0", {cpu_rst, in_ready, write_data, write_instruction, running, halted}, word_count);
    end
    exp_wc = 0; exp_err = 1'b0;
  endtask

  task automatic test_records();
    send_record("data_rec", C_DATA, 16'h0002, 32'h0000_0009, 1'b0);
    send_record("inst_rec", C_INST, 16'h0004, 32'h403F_000A, 1'b0);
  endtask

  task automatic test_run_halt();
    logic [31:0] vals [5] = '{32'd7, 32'd12, 32'd9, 32'd11, 32'd3};
    do_reset();
    for (int k = 0; k < 5; k++) send_record("load5", C_DATA, 16'(k), vals[k], 1'b0);
    checks++;
    if (cpu_rst !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL pre_go: cpu_rst=%0b running=%0b, required 1 0", cpu_rst, running); end
    send_byte(C_GO);
    checks++;
    if (cpu_rst !== 1'b0 || running !== 1'b1 || word_count !== 11'd5) begin
      errors++; $display("FAIL go_edge: cpu_rst=%0b running=%0b wc=%0d, required 0 1 5", cpu_rst, running, word_count);
    end
    tick(50);
    checks++;
    if (running !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL run_hold: running=%0b halted=%0b, required 1 0", running, halted); end
    done = 1'b1;
    tick(1);
    done = 1'b0;
    tick(3);
    checks++;
    if (halted !== 1'b1 || running !== 1'b0 || cpu_rst !== 1'b0) begin
      errors++; $display("FAIL halt: halted=%0b running=%0b cpu_rst=%0b, required 1 0 0", halted, running, cpu_rst);
    end
    send_byte(C_STOP);
    exp_wc = 0;
    checks++;
    if (cpu_rst !== 1'b1 || halted !== 1'b0 || word_count !== '0) begin
      errors++; $display("FAIL stop_from_halt: cpu_rst=%0b halted=%0b wc=%0d, required 1 0 0", cpu_rst, halted, word_count);
    end
  endtask

  task automatic test_bad_cmd();
    do_reset();
    send_record("pre_bad", C_DATA, 16'h0003, $urandom, 1'b0);
    send_byte(8'h33);
    exp_err = 1'b1;
    tick(1);
    checks++;
    if (error !== 1'b1 || word_count !== 11'd1) begin errors++; $display("FAIL bad_cmd: error=%0b wc=%0d, required 1 1", error, word_count); end
    send_record("out_of_range", C_DATA, 16'h0400, 32'h0000_0001, 1'b0);
  endtask

  task automatic test_reset_mid_record();
    int wd0;
    do_reset();
    wd0 = n_wd;
    send_byte(C_DATA); send_byte(8'h00); send_byte(8'h05); send_byte(8'hAA); send_byte(8'hBB);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || cpu_rst !== 1'b1) begin errors++; $display("FAIL mid_reset: in_ready=%0b cpu_rst=%0b, required 0 1", in_ready, cpu_rst); end
    rst = 1'b1;
    tick(1);
    exp_wc = 0; exp_err = 1'b0;
    send_record("after_mid_reset", C_DATA, 16'h0006, 32'hDEAD_BEEF, 1'b0);
    checks++;
    if (n_wd - wd0 != 1) begin errors++; $display("FAIL partial_discarded: writes=%0d, required 1", n_wd - wd0); end
  endtask

  task automatic test_stop_in_run();
    do_reset();
    send_record("pre_run", C_INST, 16'h0007, $urandom, 1'b0);
    send_byte(C_GO);
    send_byte(8'h77);
    checks++;
    if (running !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL run_ignores_byte: running=%0b error=%0b, required 1 0", running, error); end
    send_byte(C_STOP);
    exp_wc = 0;
    checks++;
    if ({cpu_rst, running, halted, in_ready} !== 4'b1001 || word_count !== '0) begin
      errors++; $display("FAIL stop_in_run: flags=%b wc=%0d, required 1001 wc=0", {cpu_rst, running, halted, in_ready}, word_count);
    end
    send_record("after_stop", C_DATA, 16'h0008, $urandom, 1'b0);
  endtask

  task automatic test_done_and_stop();
    int h0;
    do_reset();
    send_byte(C_GO);
    h0   = n_halt;
    done = 1'b1;
    send_byte(C_STOP);
    done = 1'b0;
    tick(3);
    checks++;
    if (n_halt != h0 || running !== 1'b0 || cpu_rst !== 1'b1) begin
      errors++; $display("FAIL done_and_stop: halted_cycles=%0d running=%0b cpu_rst=%0b, required 0 0 1", n_halt - h0, running, cpu_rst);
    end
  endtask

  task automatic test_random_saturation();
    int extra = 0;
    int iter  = 0;
    do_reset();
    while ((exp_wc < 1024 || extra < 3) && iter < 3000) begin
      logic [7:0]  cmd  = ($urandom_range(0, 1) == 0) ? C_DATA : C_INST;
      logic [15:0] addr = ($urandom_range(0, 15) == 0) ? 16'($urandom_range(1024, 65535))
                                                        : 16'($urandom_range(0, 1023));
      if (exp_wc == 1024) extra++;
      send_record("random", cmd, addr, $urandom, 1'b1);
      iter++;
    end
    checks++;
    if (word_count !== 11'd1024) begin errors++; $display("FAIL saturation: word_count=%0d, required 1024", word_count); end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_records();
    test_run_halt();
    test_bad_cmd();
    test_reset_mid_record();
    test_stop_in_run();
    test_done_and_stop();
    test_random_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream loader stage for the CPU.
- Accepts a byte stream over a valid/ready handshake and assembles it into 32-bit words.
- Drives the CPU load port (address, inst_data, write_instruction, write_data) while holding the CPU in reset, then releases it on command.
- Replaces hand-sequenced memory preloading with a deterministic, verifiable load protocol.

Parameters:
- ADDR_W, 10, width of CPU load address.
- DATA_W, 32, width of loaded word; fixed at 4 bytes.
- CMD_DATA, 8'h01, record targets data memory.
- CMD_INST, 8'h02, record targets instruction memory.
- CMD_GO, 8'hA5, release CPU from reset.
- CMD_STOP, 8'h5A, re-assert CPU reset and return to load mode.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  byte stream valid.
- in_data  input  8  byte stream data.
- in_ready  output  1  loader can accept a byte this cycle.
- done  input  1  CPU completion flag.
- cpu_rst  output  1  active-high reset to CPU (CPU reset polarity).
- address  output  ADDR_W  CPU load address.
- inst_data  output  DATA_W  CPU load word.
- write_instruction  output  1  one-cycle instruction-memory write strobe.
- write_data  output  1  one-cycle data-memory write strobe.
- running  output  1  CPU released (state RUN).
- halted  output  1  CPU reported done (state HALT).
- error  output  1  sticky protocol error.
- word_count  output  ADDR_W+1  records committed since last reset or STOP.

Behaviour:
- Reset (rst=0, asynchronous):
  - State=IDLE, cpu_rst=1, in_ready=0.
  - All other outputs 0, including address, inst_data, word_count and error.
  - Reset is honoured mid-record or mid-run; a partial record is discarded.
- A byte transfers only on a rising edge with in_valid=1 and in_ready=1.
- in_ready=1 in IDLE, ADDR_HI, ADDR_LO, DATA, RUN and HALT; in_ready=0 in WRITE.
- States:
  - IDLE:
    - CMD_DATA or CMD_INST: latch target, go to ADDR_HI.
    - CMD_GO: cpu_rst<=0, go to RUN.
    - CMD_STOP: no-op, stay IDLE.
    - Any other byte: error<=1, stay IDLE.
  - ADDR_HI: latch byte into addr[15:8], go to ADDR_LO.
  - ADDR_LO: latch byte into addr[7:0], clear byte counter, go to DATA.
  - DATA:
    - Four bytes, big-endian: first byte to word[31:24], last to word[7:0].
    - 2-bit byte counter; after the 4th byte go to WRITE.
  - WRITE (exactly 1 cycle):
    - address=addr[ADDR_W-1:0], inst_data=assembled word.
    - Exactly one strobe is high, per latched target; word_count increments.
    - If addr[15:ADDR_W] != 0: no strobe, word_count unchanged, error<=1.
    - Next state IDLE.
  - RUN:
    - cpu_rst=0, running=1.
    - CMD_STOP: cpu_rst<=1, word_count<=0, go to IDLE.
    - Other bytes: consumed and ignored.
    - done=1 sampled: go to HALT.
  - HALT: running=0, halted=1, cpu_rst stays 0; CMD_STOP goes to IDLE as in RUN.
- Output timing:
  - Strobes are registered and high only during the WRITE cycle.
  - address and inst_data hold their last values afterwards.
- Latency: the last data byte accepted at edge N produces the strobe in the cycle after edge N, visible at edge N+1.
- cpu_rst is registered; it changes on the edge that accepts GO or STOP.
- If done and a CMD_STOP byte arrive in the same RUN cycle, STOP wins and the state goes to IDLE.
- word_count saturates at 2^ADDR_W; it does not wrap.
- error clears only on reset.

Test Plan:
- Reset then idle, rst released:
  - Required: cpu_rst=1, in_ready=1, all strobes 0, word_count=0.
- Stream 01 00 02 00 00 00 09:
  - Required: one cycle with write_data=1, write_instruction=0, address=2, inst_data=9; word_count=1.
- Stream 02 00 04 40 3F 00 0A:
  - Required: write_instruction=1 for one cycle, address=4, inst_data=32'h403F000A.
- Load five data words 7,12,9,11,3 at addresses 0..4, then A5; drive done=1 after 50 cycles:
  - Required: word_count=5, cpu_rst falls on the GO edge, running=1, then halted=1.
- Bad command byte 33, then stream 01 04 00 00 00 00 01 (address 0x400):
  - Required: error=1, no strobe, word_count unchanged.
- rst pulsed low after the 2nd data byte of a record, then a full valid record:
  - Required: only the second record is written, with correct assembly.
- In RUN, send 5A:
  - Required: cpu_rst=1 on the next edge, state IDLE, word_count=0.
- In RUN, done=1 in the same cycle as 5A:
  - Required: state IDLE, halted never asserted.
